// File: rtl/armleocpu_writeback_arbiter_if.sv
// Write-back arbiter bus: requester handshakes, regfile write port,
// destination-register reservation and scoreboard query signals.
interface armleocpu_writeback_arbiter_if;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd_addr;
  logic [95:0] req_rd_wdata;
  logic        rd_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        reserve_valid;
  logic [4:0]  reserve_addr;
  logic        reserve_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;

  modport slave (
    input  req_valid, req_rd_addr, req_rd_wdata,
    input  reserve_valid, reserve_addr, rs1_addr, rs2_addr,
    output req_ready, rd_write, rd_addr, rd_wdata,
    output reserve_ready, rs1_busy, rs2_busy
  );

  modport master (
    output req_valid, req_rd_addr, req_rd_wdata,
    output reserve_valid, reserve_addr, rs1_addr, rs2_addr,
    input  req_ready, rd_write, rd_addr, rd_wdata,
    input  reserve_ready, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/armleocpu_writeback_arbiter.sv
// Write-back arbiter with register scoreboard.
// Three requesters compete for one regfile write port; the winner's write
// lands one edge after acceptance. A 32-entry busy vector tracks registers
// reserved by issue and cleared by the registered write.
// Optional macro ARMLEOCPU_WB_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined, requester 0 has fixed highest priority.
module armleocpu_writeback_arbiter (
  input logic                            clk,
  input logic                            async_rst_n,
  armleocpu_writeback_arbiter_if.slave   bus
);

  logic        gnt_any;
  logic [1:0]  gnt_idx;
  logic [4:0]  sel_addr;
  logic [31:0] sel_wdata;

  logic        rd_write_p1;
  logic [4:0]  rd_addr_p1;
  logic [31:0] rd_wdata_p1;

  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] busy_set;
  logic [31:0] busy_clr;

  // First valid requester in the order a, b, c; returns {found, index}
  function automatic logic [2:0] pick3(input logic [2:0] v,
                                       input logic [1:0] a,
                                       input logic [1:0] b,
                                       input logic [1:0] c);
    if (v[a])      pick3 = {1'b1, a};
    else if (v[b]) pick3 = {1'b1, b};
    else if (v[c]) pick3 = {1'b1, c};
    else           pick3 = 3'b000;
  endfunction

`ifdef ARMLEOCPU_WB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  // Rotating-priority pick starting at the pointer; pointer moves past the winner
  always_comb begin
    logic [2:0] res;
    res = 3'b000;
    unique case (ptr_q)
      2'd1:    res = pick3(bus.req_valid, 2'd1, 2'd2, 2'd0);
      2'd2:    res = pick3(bus.req_valid, 2'd2, 2'd0, 2'd1);
      default: res = pick3(bus.req_valid, 2'd0, 2'd1, 2'd2);
    endcase
    gnt_any = res[2];
    gnt_idx = res[1:0];
    ptr_d   = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) ptr_q <= 2'd0;
    else              ptr_q <= ptr_d;
  end
`else
  // Fixed priority pick: requester 0 beats 1 beats 2
  always_comb begin
    logic [2:0] res;
    res     = pick3(bus.req_valid, 2'd0, 2'd1, 2'd2);
    gnt_any = res[2];
    gnt_idx = res[1:0];
  end
`endif

  // Route the winner's destination and data; one-hot ready back to requesters
  always_comb begin
    sel_addr  = bus.req_rd_addr[4:0];
    sel_wdata = bus.req_rd_wdata[31:0];
    unique case (gnt_idx)
      2'd1: begin
        sel_addr  = bus.req_rd_addr[9:5];
        sel_wdata = bus.req_rd_wdata[63:32];
      end
      2'd2: begin
        sel_addr  = bus.req_rd_addr[14:10];
        sel_wdata = bus.req_rd_wdata[95:64];
      end
      default: ;
    endcase
    bus.req_ready = gnt_any ? (3'b001 << gnt_idx) : 3'b000;
  end

  // Stage boundary p0 -> p1: registered regfile write; x0 writes are swallowed
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rd_write_p1 <= 1'b0;
      rd_addr_p1  <= 5'd0;
      rd_wdata_p1 <= 32'd0;
    end else begin
      rd_write_p1 <= gnt_any && (sel_addr != 5'd0);
      if (gnt_any) begin
        rd_addr_p1  <= sel_addr;
        rd_wdata_p1 <= sel_wdata;
      end
    end
  end

  assign bus.rd_write = rd_write_p1;
  assign bus.rd_addr  = rd_addr_p1;
  assign bus.rd_wdata = rd_wdata_p1;

  // Scoreboard update: clear on the regfile write, set on accepted reservation (set wins)
  always_comb begin
    bus.reserve_ready = (bus.reserve_addr == 5'd0) || !busy_q[bus.reserve_addr];
    busy_clr = rd_write_p1 ? (32'd1 << rd_addr_p1) : 32'd0;
    busy_set = (bus.reserve_valid && bus.reserve_ready && (bus.reserve_addr != 5'd0))
               ? (32'd1 << bus.reserve_addr) : 32'd0;
    busy_d   = ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) busy_q <= 32'd0;
    else              busy_q <= busy_d;
  end

  assign bus.rs1_busy = busy_q[bus.rs1_addr];
  assign bus.rs2_busy = busy_q[bus.rs2_addr];

endmodule

// File: tb/tb_armleocpu_writeback_arbiter.sv
// Directed bench for armleocpu_writeback_arbiter.
module tb_armleocpu_writeback_arbiter;

  logic clk = 1'b0;
  logic async_rst_n;
  int   tests = 0;
  int   fails = 0;

  armleocpu_writeback_arbiter_if bus();

  armleocpu_writeback_arbiter dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  exp_rdy [4];
  logic [4:0]  exp_adr [4];
  logic [31:0] exp_dat [4];

  initial begin
`ifdef ARMLEOCPU_WB_ROUND_ROBIN_EN
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_adr = '{5'd1, 5'd2, 5'd3, 5'd1};
    exp_dat = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hAAAA0001};
`else
    exp_rdy = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_adr = '{5'd1, 5'd1, 5'd1, 5'd1};
    exp_dat = '{32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001};
`endif

    async_rst_n       = 1'b0;
    bus.req_valid     = 3'b000;
    bus.req_rd_addr   = 15'd0;
    bus.req_rd_wdata  = 96'd0;
    bus.reserve_valid = 1'b0;
    bus.reserve_addr  = 5'd0;
    bus.rs1_addr      = 5'd5;
    bus.rs2_addr      = 5'd0;
    #2;
    chk("rst_rd_write", 32'(bus.rd_write), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_rd_wdata", bus.rd_wdata, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
    tick();

    // Reserve x5, query, re-reserve
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd5;
    #1;
    chk("res5_ready", 32'(bus.reserve_ready), 32'd1);
    chk("res5_nobypass", 32'(bus.rs1_busy), 32'd0);
    tick();
    bus.reserve_valid = 1'b0;
    chk("res5_busy", 32'(bus.rs1_busy), 32'd1);
    bus.reserve_valid = 1'b1;
    #1;
    chk("res5_again_ready", 32'(bus.reserve_ready), 32'd0);
    bus.reserve_valid = 1'b0;

    // Write-back x5 from requester 0
    bus.req_valid    = 3'b001;
    bus.req_rd_addr  = 15'd5;
    bus.req_rd_wdata = {64'd0, 32'hFF00FF00};
    #1;
    chk("wb5_ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b000;
    chk("wb5_write", 32'(bus.rd_write), 32'd1);
    chk("wb5_addr", 32'(bus.rd_addr), 32'd5);
    chk("wb5_data", bus.rd_wdata, 32'hFF00FF00);
    chk("wb5_busy_pre", 32'(bus.rs1_busy), 32'd1);
    tick();
    chk("wb5_write_off", 32'(bus.rd_write), 32'd0);
    chk("wb5_addr_hold", 32'(bus.rd_addr), 32'd5);
    chk("wb5_data_hold", bus.rd_wdata, 32'hFF00FF00);
    chk("wb5_busy_clr", 32'(bus.rs1_busy), 32'd0);

    // Reset asserted mid-cycle with a pending write and x9 busy
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd9;
    tick();
    bus.reserve_valid = 1'b0;
    bus.req_valid     = 3'b001;
    bus.req_rd_addr   = 15'd9;
    bus.req_rd_wdata  = {64'd0, 32'hCAFE0009};
    tick();
    bus.req_valid = 3'b000;
    bus.rs1_addr  = 5'd9;
    #1;
    chk("r9_write", 32'(bus.rd_write), 32'd1);
    chk("r9_busy", 32'(bus.rs1_busy), 32'd1);
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("mrst_write", 32'(bus.rd_write), 32'd0);
    chk("mrst_addr", 32'(bus.rd_addr), 32'd0);
    chk("mrst_data", bus.rd_wdata, 32'd0);
    chk("mrst_busy9", 32'(bus.rs1_busy), 32'd0);
    tick();
    async_rst_n = 1'b1;
    tick();
    chk("mrst_release_write", 32'(bus.rd_write), 32'd0);
    chk("mrst_release_busy9", 32'(bus.rs1_busy), 32'd0);

    // All three requesters valid for four cycles
    bus.req_rd_addr  = {5'd3, 5'd2, 5'd1};
    bus.req_rd_wdata = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    bus.req_valid    = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("arb%0d_ready", k), 32'(bus.req_ready), 32'(exp_rdy[k]));
      tick();
      chk($sformatf("arb%0d_addr", k), 32'(bus.rd_addr), 32'(exp_adr[k]));
      chk($sformatf("arb%0d_data", k), bus.rd_wdata, exp_dat[k]);
      chk($sformatf("arb%0d_write", k), 32'(bus.rd_write), 32'd1);
    end
    bus.req_valid = 3'b000;
    tick();

    // Write-back to x0 is consumed but never written
    bus.req_valid    = 3'b001;
    bus.req_rd_addr  = 15'd0;
    bus.req_rd_wdata = {64'd0, 32'h12345678};
    #1;
    chk("x0_ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b000;
    chk("x0_write", 32'(bus.rd_write), 32'd0);
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd0;
    bus.rs2_addr      = 5'd0;
    #1;
    chk("x0_res_ready", 32'(bus.reserve_ready), 32'd1);
    chk("x0_rs2_busy", 32'(bus.rs2_busy), 32'd0);
    tick();
    bus.reserve_valid = 1'b0;
    chk("x0_rs2_busy_after", 32'(bus.rs2_busy), 32'd0);

    // Reserve of a register clearing this cycle is refused
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd7;
    tick();
    bus.reserve_valid = 1'b0;
    bus.req_valid     = 3'b001;
    bus.req_rd_addr   = 15'd7;
    bus.req_rd_wdata  = {64'd0, 32'h00000077};
    tick();
    bus.req_valid = 3'b000;
    chk("c7_write", 32'(bus.rd_write), 32'd1);
    chk("c7_addr", 32'(bus.rd_addr), 32'd7);
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd7;
    #1;
    chk("c7_res_ready", 32'(bus.reserve_ready), 32'd0);
    tick();
    bus.reserve_valid = 1'b0;
    bus.rs1_addr      = 5'd7;
    #1;
    chk("c7_busy_after", 32'(bus.rs1_busy), 32'd0);

    // Reserve x3 while x7 clears: both take effect
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd7;
    #1;
    chk("r7_ready", 32'(bus.reserve_ready), 32'd1);
    tick();
    bus.reserve_valid = 1'b0;
    bus.req_valid     = 3'b001;
    tick();
    bus.req_valid     = 3'b000;
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd3;
    #1;
    chk("r3_ready", 32'(bus.reserve_ready), 32'd1);
    tick();
    bus.reserve_valid = 1'b0;
    bus.rs1_addr      = 5'd7;
    bus.rs2_addr      = 5'd3;
    #1;
    chk("r7_cleared", 32'(bus.rs1_busy), 32'd0);
    chk("r3_set", 32'(bus.rs2_busy), 32'd1);

    // Write to non-busy x4 with same-cycle reserve of x4: set wins
    bus.req_valid    = 3'b010;
    bus.req_rd_addr  = {5'd0, 5'd4, 5'd0};
    bus.req_rd_wdata = {32'd0, 32'h44444444, 32'd0};
    #1;
    chk("x4_ready", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = 3'b000;
    chk("x4_write", 32'(bus.rd_write), 32'd1);
    chk("x4_data", bus.rd_wdata, 32'h44444444);
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd4;
    #1;
    chk("x4_res_ready", 32'(bus.reserve_ready), 32'd1);
    tick();
    bus.reserve_valid = 1'b0;
    bus.rs1_addr      = 5'd4;
    #1;
    chk("x4_set_wins", 32'(bus.rs1_busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
